// File: rtl/fir_seq_ctrl.sv
// Control/sequencing engine for the 11-tap FIR: start/done handshake, circular data buffer, MAC addressing, tap BRAM arbitration.
// Optional: define FIR_SEQ_STALL_CNT_EN to build the output back-pressure cycle counter on stall_cnt.
module fir_seq_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   ap_start,
  input  logic [pDATA_WIDTH-1:0] data_length,
  output logic                   ap_idle,
  output logic                   ap_done,
  output logic                   err_tlast,
  input  logic                   ss_tvalid,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic                   sm_tlast,
  output logic                   data_EN,
  output logic [3:0]             data_WE,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic                   data_zero,
  input  logic                   cfg_tap_req,
  input  logic [3:0]             cfg_tap_WE,
  input  logic [pADDR_WIDTH-1:0] cfg_tap_A,
  output logic                   cfg_tap_gnt,
  output logic                   tap_EN,
  output logic [3:0]             tap_WE,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic                   mac_clr,
  output logic                   mac_en,
  output logic [pDATA_WIDTH-1:0] stall_cnt
);

  localparam int IW = $clog2(Tape_Num + 1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_WAIT_IN, S_MAC, S_OUT} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [IW-1:0]          wptr_q, wptr_d;
  logic [pDATA_WIDTH-1:0] cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   last_smp;
  logic [IW-1:0]          rd_idx;

  function automatic logic [pADDR_WIDTH-1:0] byte_addr(input logic [IW-1:0] i);
    return pADDR_WIDTH'(i) << 2;
  endfunction

  assign last_smp  = (cnt_q == data_length - pDATA_WIDTH'(1));
  // Newest sample sits at wptr; tap m pairs with the sample m positions older.
  assign rd_idx    = (wptr_q >= idx_q) ? (wptr_q - idx_q)
                                       : (wptr_q + IW'(Tape_Num) - idx_q);
  assign ap_idle   = (state_q == S_IDLE);
  assign ap_done   = done_q;
  assign err_tlast = err_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wptr_d      = wptr_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    err_d       = err_q;
    ss_tready   = 1'b0;
    sm_tvalid   = 1'b0;
    sm_tlast    = 1'b0;
    data_EN     = 1'b0;
    data_WE     = 4'h0;
    data_A      = '0;
    data_zero   = 1'b0;
    cfg_tap_gnt = 1'b0;
    tap_EN      = 1'b0;
    tap_WE      = 4'h0;
    tap_A       = '0;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cfg_tap_gnt = cfg_tap_req;
        tap_EN      = cfg_tap_req;
        tap_WE      = cfg_tap_req ? cfg_tap_WE : 4'h0;
        tap_A       = cfg_tap_A;
        if (ap_start) begin
          state_d = S_INIT;
          idx_d   = '0;
          wptr_d  = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_INIT: begin
        data_EN   = 1'b1;
        data_WE   = 4'hF;
        data_zero = 1'b1;
        data_A    = byte_addr(idx_q);
        if (idx_q == IW'(Tape_Num - 1)) begin
          idx_d = '0;
          if (data_length == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT_IN;
          end
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_WAIT_IN: begin
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          data_EN = 1'b1;
          data_WE = 4'hF;
          data_A  = byte_addr(wptr_q);
          state_d = S_MAC;
          idx_d   = '0;
          if (ss_tlast != last_smp) err_d = 1'b1;
        end
      end
      S_MAC: begin
        // One extra cycle at the end absorbs the BRAM read latency.
        if (idx_q < IW'(Tape_Num)) begin
          tap_EN  = 1'b1;
          tap_A   = byte_addr(idx_q);
          data_EN = 1'b1;
          data_A  = byte_addr(rd_idx);
        end
        mac_clr = (idx_q == '0);
        mac_en  = (idx_q != '0);
        if (idx_q == IW'(Tape_Num)) begin
          state_d = S_OUT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_OUT: begin
        sm_tvalid = 1'b1;
        sm_tlast  = last_smp;
        if (sm_tready) begin
          wptr_d = (wptr_q == IW'(Tape_Num - 1)) ? '0 : wptr_q + IW'(1);
          cnt_d  = cnt_q + pDATA_WIDTH'(1);
          if (last_smp) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT_IN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Suppress data BRAM writes in the cycle reset is asserted.
    if (axis_rst) begin
      data_EN = 1'b0;
      data_WE = 4'h0;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef FIR_SEQ_STALL_CNT_EN
  logic [pDATA_WIDTH-1:0] stall_q;

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      stall_q <= '0;
    end else if (state_q == S_IDLE && ap_start) begin
      stall_q <= '0;
    end else if (state_q == S_OUT && !sm_tready && stall_q != '1) begin
      stall_q <= stall_q + pDATA_WIDTH'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl with behavioural tap/data BRAMs and MAC around the controller.
module tb_fir_seq_ctrl;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NT = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          ap_start;
  logic [DW-1:0] data_length;
  logic          ap_idle, ap_done, err_tlast;
  logic          ss_tvalid, ss_tlast, ss_tready;
  logic          sm_tready, sm_tvalid, sm_tlast;
  logic          data_EN, data_zero;
  logic [3:0]    data_WE;
  logic [AW-1:0] data_A;
  logic          cfg_tap_req, cfg_tap_gnt;
  logic [3:0]    cfg_tap_WE;
  logic [AW-1:0] cfg_tap_A;
  logic          tap_EN;
  logic [3:0]    tap_WE;
  logic [AW-1:0] tap_A;
  logic          mac_clr, mac_en;
  logic [DW-1:0] stall_cnt;

  logic signed [31:0] ss_tdata, cfg_wdata;
  logic signed [31:0] dmem [NT];
  logic signed [31:0] tmem [NT];
  logic signed [31:0] data_Do, tap_Do, acc;

  int n_vec = 0;
  int n_bad = 0;
  int viol  = 0;
  logic mon_en = 1'b0;
  int taps [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  always #5 clk = ~clk;

  fir_seq_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
    .axis_clk(clk), .axis_rst(rst), .ap_start(ap_start), .data_length(data_length),
    .ap_idle(ap_idle), .ap_done(ap_done), .err_tlast(err_tlast),
    .ss_tvalid(ss_tvalid), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tready(sm_tready), .sm_tvalid(sm_tvalid), .sm_tlast(sm_tlast),
    .data_EN(data_EN), .data_WE(data_WE), .data_A(data_A), .data_zero(data_zero),
    .cfg_tap_req(cfg_tap_req), .cfg_tap_WE(cfg_tap_WE), .cfg_tap_A(cfg_tap_A),
    .cfg_tap_gnt(cfg_tap_gnt), .tap_EN(tap_EN), .tap_WE(tap_WE), .tap_A(tap_A),
    .mac_clr(mac_clr), .mac_en(mac_en), .stall_cnt(stall_cnt)
  );

  // Datapath model: 1-cycle-latency BRAMs and accumulator; sm_tdata is acc.
  always @(posedge clk) begin
    if (data_EN && data_A[AW-1:2] < NT) begin
      if (data_WE != 4'h0) dmem[data_A[AW-1:2]] <= data_zero ? 32'sd0 : ss_tdata;
      data_Do <= dmem[data_A[AW-1:2]];
    end
    if (tap_EN && tap_A[AW-1:2] < NT) begin
      if (tap_WE != 4'h0) tmem[tap_A[AW-1:2]] <= cfg_wdata;
      tap_Do <= tmem[tap_A[AW-1:2]];
    end
    if (mac_clr) acc <= 32'sd0;
    else if (mac_en) acc <= acc + tap_Do * data_Do;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (!ap_idle && cfg_tap_gnt) viol++;
      if (!ap_idle && tap_WE != 4'h0) viol++;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    ap_start = 1'b1;
    step;
    ap_start = 1'b0;
  endtask

  task automatic load_taps;
    for (int i = 0; i < NT; i++) begin
      cfg_tap_req = 1'b1; cfg_tap_WE = 4'hF; cfg_tap_A = AW'(4 * i); cfg_wdata = taps[i];
      #1;
      n_vec++;
      if (cfg_tap_gnt !== 1'b1) begin
        $display("FAIL cfg_gnt_idle tap %0d: got %b expected 1", i, cfg_tap_gnt); n_bad++;
      end
      step;
    end
    cfg_tap_req = 1'b0; cfg_tap_WE = 4'h0;
  endtask

  task automatic feed(input int i, input logic signed [31:0] x, input logic lst,
                      input int nstall, output logic signed [31:0] y, output logic yl);
    int k;
    logic signed [31:0] hold;
    ss_tdata = x; ss_tlast = lst; ss_tvalid = 1'b1;
    #1;
    k = 0;
    while (!ss_tready && k < 200) begin step; k++; end
    n_vec++;
    if (ss_tready !== 1'b1) begin
      $display("FAIL ss_tready_wait sample %0d: got %b expected 1 within 200 cycles", i, ss_tready); n_bad++;
    end
    n_vec++;
    if (data_WE !== 4'hF || data_A !== AW'(4 * (i % NT))) begin
      $display("FAIL wr_addr sample %0d: got WE=%h A=%0d expected WE=f A=%0d", i, data_WE, data_A, 4 * (i % NT)); n_bad++;
    end
    step;
    ss_tvalid = 1'b0; ss_tlast = 1'b0;
    k = 0;
    while (!sm_tvalid && k < 200) begin step; k++; end
    n_vec++;
    if (k !== 12) begin
      $display("FAIL latency sample %0d: got %0d edges expected 12", i, k); n_bad++;
    end
    hold = acc;
    for (int s = 0; s < nstall; s++) begin
      step;
      n_vec++;
      if (sm_tvalid !== 1'b1 || acc !== hold) begin
        $display("FAIL stall_hold sample %0d: got vld=%b data=%0d expected vld=1 data=%0d", i, sm_tvalid, acc, hold); n_bad++;
      end
    end
    y = acc; yl = sm_tlast;
    sm_tready = 1'b1;
    step;
    sm_tready = 1'b0;
  endtask

  task automatic test_reset;
    int k, w;
    rst = 1'b1;
    step; step;
    rst = 1'b0;
    step;
    n_vec++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0 || ss_tready !== 1'b0 || sm_tvalid !== 1'b0 ||
        err_tlast !== 1'b0 || data_EN !== 1'b0 || stall_cnt !== '0) begin
      $display("FAIL reset_state: got idle=%b done=%b ssr=%b smv=%b err=%b den=%b stall=%0d expected 1 0 0 0 0 0 0",
               ap_idle, ap_done, ss_tready, sm_tvalid, err_tlast, data_EN, stall_cnt); n_bad++;
    end
    data_length = 5;
    pulse_start;
    ss_tdata = 7; ss_tvalid = 1'b1;
    k = 0;
    while (!ss_tready && k < 50) begin step; k++; end
    step;
    ss_tvalid = 1'b0;
    step; step; step; step;
    n_vec++;
    if (data_EN !== 1'b1 || data_WE !== 4'h0 || mac_en !== 1'b1) begin
      $display("FAIL in_mac_before_rst: got den=%b we=%h mac_en=%b expected 1 0 1", data_EN, data_WE, mac_en); n_bad++;
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (data_WE !== 4'h0) begin
      $display("FAIL rst_cycle_we: got %h expected 0", data_WE); n_bad++;
    end
    step;
    rst = 1'b0;
    #1;
    n_vec++;
    if (ap_idle !== 1'b1 || sm_tvalid !== 1'b0 || ap_done !== 1'b0) begin
      $display("FAIL mid_mac_reset: got idle=%b smv=%b done=%b expected 1 0 0", ap_idle, sm_tvalid, ap_done); n_bad++;
    end
    w = 0;
    for (int c = 0; c < 20; c++) begin
      if (data_WE !== 4'h0 || data_EN !== 1'b0) w++;
      step;
    end
    n_vec++;
    if (w !== 0) begin
      $display("FAIL post_reset_writes: got %0d active cycles expected 0", w); n_bad++;
    end
  endtask

  task automatic test_impulse;
    logic signed [31:0] y;
    logic yl;
    load_taps;
    data_length = 11;
    pulse_start;
    for (int i = 0; i < NT; i++) begin
      feed(i, (i == 0) ? 32'sd1 : 32'sd0, i == NT - 1, i % 3, y, yl);
      n_vec++;
      if (y !== taps[i]) begin
        $display("FAIL impulse_out %0d: got %0d expected %0d", i, y, taps[i]); n_bad++;
      end
      n_vec++;
      if (yl !== (i == NT - 1)) begin
        $display("FAIL impulse_tlast %0d: got %b expected %b", i, yl, i == NT - 1); n_bad++;
      end
    end
    n_vec++;
    if (ap_done !== 1'b1 || ap_idle !== 1'b1) begin
      $display("FAIL impulse_done: got done=%b idle=%b expected 1 1", ap_done, ap_idle); n_bad++;
    end
  endtask

  task automatic test_long;
    int xh [600];
    int gold, p;
    logic signed [31:0] y;
    logic yl;
    data_length = 600;
    pulse_start;
    for (int i = 0; i < 600; i++) begin
      p = i % 40;
      xh[i] = (p < 20) ? (p * 5 - 50) : ((40 - p) * 5 - 50);
      gold = 0;
      for (int m = 0; m < NT; m++) if (i - m >= 0) gold += taps[m] * xh[i - m];
      feed(i, xh[i], i == 599, int'($urandom_range(0, 3)), y, yl);
      n_vec++;
      if (y !== gold || yl !== (i == 599)) begin
        $display("FAIL long_out %0d: got %0d last=%b expected %0d last=%b", i, y, yl, gold, i == 599); n_bad++;
      end
    end
    n_vec++;
    if (ap_done !== 1'b1 || ap_idle !== 1'b1) begin
      $display("FAIL long_done: got done=%b idle=%b expected 1 1", ap_done, ap_idle); n_bad++;
    end
  endtask

  task automatic test_cfg_busy;
    logic signed [31:0] y;
    logic yl;
    data_length = 2;
    pulse_start;
    viol = 0; mon_en = 1'b1;
    cfg_tap_req = 1'b1; cfg_tap_WE = 4'hF; cfg_tap_A = 20; cfg_wdata = 100;
    feed(0, 32'sd3, 1'b0, 0, y, yl);
    pulse_start;
    n_vec++;
    if (ap_idle !== 1'b0) begin
      $display("FAIL start_ignored_busy: got idle=%b expected 0", ap_idle); n_bad++;
    end
    feed(1, 32'sd0, 1'b1, 2, y, yl);
    n_vec++;
    if (yl !== 1'b1 || ap_done !== 1'b1) begin
      $display("FAIL busy_run_end: got last=%b done=%b expected 1 1", yl, ap_done); n_bad++;
    end
    mon_en = 1'b0;
    n_vec++;
    if (viol !== 0) begin
      $display("FAIL busy_gnt_or_write: got %0d violations expected 0", viol); n_bad++;
    end
    n_vec++;
    if (tmem[5] !== 32'sd63 || cfg_tap_gnt !== 1'b1) begin
      $display("FAIL cfg_blocked_then_gnt: got tap5=%0d gnt=%b expected 63 1", tmem[5], cfg_tap_gnt); n_bad++;
    end
    step;
    cfg_tap_req = 1'b0; cfg_tap_WE = 4'h0;
    n_vec++;
    if (tmem[5] !== 32'sd100) begin
      $display("FAIL cfg_write_lands: got %0d expected 100", tmem[5]); n_bad++;
    end
    load_taps;
  endtask

  task automatic test_tlast_err;
    logic signed [31:0] y;
    logic yl;
    data_length = 3;
    pulse_start;
    for (int i = 0; i < 3; i++) begin
      feed(i, 32'sd1, i == 1, 0, y, yl);
      if (i == 1) begin
        n_vec++;
        if (err_tlast !== 1'b1) begin
          $display("FAIL err_tlast_set: got %b expected 1", err_tlast); n_bad++;
        end
      end
    end
    n_vec++;
    if (yl !== 1'b1 || ap_done !== 1'b1 || err_tlast !== 1'b1) begin
      $display("FAIL len3_end: got last=%b done=%b err=%b expected 1 1 1", yl, ap_done, err_tlast); n_bad++;
    end
    data_length = 0;
    pulse_start;
    n_vec++;
    if (ap_done !== 1'b0 || err_tlast !== 1'b0 || ap_idle !== 1'b0) begin
      $display("FAIL start_clears: got done=%b err=%b idle=%b expected 0 0 0", ap_done, err_tlast, ap_idle); n_bad++;
    end
    for (int i = 0; i < NT; i++) begin
      n_vec++;
      if (data_WE !== 4'hF || data_zero !== 1'b1 || data_A !== AW'(4 * i) || ss_tready !== 1'b0) begin
        $display("FAIL init_fill %0d: got we=%h zero=%b A=%0d ssr=%b expected f 1 %0d 0", i, data_WE, data_zero, data_A, ss_tready, 4 * i); n_bad++;
      end
      step;
    end
    n_vec++;
    if (ap_done !== 1'b1 || ap_idle !== 1'b1 || ss_tready !== 1'b0) begin
      $display("FAIL len0_done: got done=%b idle=%b ssr=%b expected 1 1 0", ap_done, ap_idle, ss_tready); n_bad++;
    end
  endtask

  task automatic test_stall_cnt;
    logic signed [31:0] y;
    logic yl;
    logic [DW-1:0] exp_cnt;
`ifdef FIR_SEQ_STALL_CNT_EN
    exp_cnt = 15;
`else
    exp_cnt = 0;
`endif
    data_length = 3;
    pulse_start;
    n_vec++;
    if (stall_cnt !== '0) begin
      $display("FAIL stall_clear_on_start: got %0d expected 0", stall_cnt); n_bad++;
    end
    for (int i = 0; i < 3; i++) feed(i, 32'sd2, i == 2, 5, y, yl);
    n_vec++;
    if (stall_cnt !== exp_cnt) begin
      $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, exp_cnt); n_bad++;
    end
  endtask

  initial begin
    rst = 1'b1; ap_start = 1'b0; data_length = '0;
    ss_tvalid = 1'b0; ss_tlast = 1'b0; ss_tdata = '0; sm_tready = 1'b0;
    cfg_tap_req = 1'b0; cfg_tap_WE = 4'h0; cfg_tap_A = '0; cfg_wdata = '0;
    acc = '0; data_Do = '0; tap_Do = '0;
    for (int i = 0; i < NT; i++) begin dmem[i] = 32'sh1234; tmem[i] = '0; end
    test_reset;
    test_impulse;
    test_long;
    test_cfg_busy;
    test_tlast_err;
    test_stall_cnt;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
